// File: rtl/zero_run_arb_pkg.sv
// ============================================================================
// Module  : zero_run_arb_pkg
// Brief   : Shared state encoding and default sizing for the zero-run arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package zero_run_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int FRAME_LEN_DEF = 8;
  localparam int RUN_LEN_DEF   = 3;

endpackage

`default_nettype wire

// File: rtl/zero_run_counter.sv
// ============================================================================
// Module  : zero_run_counter
// Brief   : Saturating consecutive-zero counter with a registered active-low hit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module zero_run_counter
  import zero_run_arb_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic bit_i,
  output logic detect_o,
  output logic found_n_o
);

  localparam int ZW = $clog2(RUN_LEN + 1);

  logic [ZW-1:0] zrun_q, zrun_d;
  logic          found_n_q, found_n_d;
  logic          w_detect;

  // Overlapping detection: a saturated count keeps hitting on every further zero.
  assign w_detect = enable_i && !bit_i && ((int'(zrun_q) + 1) >= RUN_LEN);

  always_comb begin
    zrun_d    = zrun_q;
    found_n_d = !w_detect;
    if (clear_i) begin
      zrun_d = '0;
    end else if (enable_i) begin
      if (bit_i) begin
        zrun_d = '0;
      end else if (zrun_q != ZW'(RUN_LEN)) begin
        zrun_d = zrun_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      zrun_q    <= '0;
      found_n_q <= 1'b1;
    end else begin
      zrun_q    <= zrun_d;
      found_n_q <= found_n_d;
    end
  end

  assign detect_o  = w_detect;
  assign found_n_o = found_n_q;

endmodule

`default_nettype wire

// File: rtl/zero_run_stream_arbiter.sv
// ============================================================================
// Module  : zero_run_stream_arbiter
// Brief   : Round-robin sharing of one zero-run detector across serial streams.
//           Define EARLY_RELEASE_EN to end a frame on its first detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module zero_run_stream_arbiter
  import zero_run_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int RUN_LEN   = RUN_LEN_DEF
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         bit_in_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       busy_o,
  output logic                       found_N_o,
  output logic [$clog2(NUM_REQ)-1:0] found_id_o,
  output logic                       done_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int FCW = $clog2(FRAME_LEN + 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] found_id_q, found_id_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

  logic           w_pick_valid;
  logic [IDW-1:0] w_pick_idx;
  logic           w_cnt_clear;
  logic           w_cnt_en;
  logic           w_detect;
  logic           w_bit;

  // First set request at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx          = 0;
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!w_pick_valid && req_i[IDW'(idx)]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    found_id_d  = found_id_q;
    frame_cnt_d = frame_cnt_q;
    w_cnt_clear = 1'b0;
    w_cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        w_cnt_clear = 1'b1;
        frame_cnt_d = '0;
        if (w_pick_valid) begin
          state_d    = RUN;
          found_id_d = w_pick_idx;
          rr_ptr_d   = IDW'((int'(w_pick_idx) + 1) % NUM_REQ);
        end
      end
      RUN: begin
        w_cnt_en    = 1'b1;
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (frame_cnt_q == FCW'(FRAME_LEN - 1)) begin
          state_d = DONE;
        end
`ifdef EARLY_RELEASE_EN
        if (w_detect) begin
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      found_id_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      found_id_q  <= found_id_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign w_bit = bit_in_i[found_id_q];

  zero_run_counter #(
    .RUN_LEN (RUN_LEN)
  ) u_counter (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .clear_i   (w_cnt_clear),
    .enable_i  (w_cnt_en),
    .bit_i     (w_bit),
    .detect_o  (w_detect),
    .found_n_o (found_N_o)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant
    assign grant_o[g] = (state_q == RUN) && (found_id_q == IDW'(g));
  end

  assign busy_o     = (state_q == RUN);
  assign done_o     = (state_q == DONE);
  assign found_id_o = found_id_q;

endmodule

`default_nettype wire

// File: tb/tb_zero_run_stream_arbiter.sv
// ============================================================================
// Module  : tb_zero_run_stream_arbiter
// Brief   : Directed, scoreboarded bench for zero_run_stream_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zero_run_stream_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic [3:0] grant;
  logic       busy;
  logic       found_N;
  logic [1:0] found_id;
  logic       done;

  int   n_tests;
  int   n_fail;
  logic exp_q[$];

`ifdef EARLY_RELEASE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  zero_run_stream_arbiter #(
    .NUM_REQ   (4),
    .FRAME_LEN (8),
    .RUN_LEN   (3)
  ) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .req_i      (req),
    .bit_in_i   (bit_in),
    .grant_o    (grant),
    .busy_o     (busy),
    .found_N_o  (found_N),
    .found_id_o (found_id),
    .done_o     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " grant"}, 32'(grant), 32'h0);
    chk({tag, " busy"},  32'(busy),  32'h0);
    chk({tag, " done"},  32'(done),  32'h0);
    chk({tag, " foundN"}, 32'(found_N), 32'h1);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = '0;
    bit_in = '0;
    step();
    step();
    chk_idle("reset");
    chk("reset found_id", 32'(found_id), 32'h0);
    reset = 1'b0;
  endtask

  // One full grant: request, FRAME samples (bits[k] is sample k), DONE, IDLE.
  task automatic do_frame(input string tag, input logic [3:0] r,
                          input logic [7:0] bits, input int id);
    int         zr;
    logic       det;
    logic       end_frame;
    logic       exp_fn;
    logic [3:0] b;
    req = r;
    step();
    chk({tag, " grant"},    32'(grant),    32'(4'b0001 << id));
    chk({tag, " busy"},     32'(busy),     32'h1);
    chk({tag, " found_id"}, 32'(found_id), 32'(id));
    zr = 0;
    for (int k = 0; k < 8; k++) begin
      b      = 4'($urandom);
      b[id]  = bits[k];
      bit_in = b;
      det    = (bits[k] == 1'b0) && (zr + 1 >= 3);
      zr     = bits[k] ? 0 : ((zr + 1 > 3) ? 3 : zr + 1);
      exp_q.push_back(!det);
      end_frame = (k == 7) || (EARLY && det);
      step();
      if (exp_q.size() == 0) begin
        chk({tag, " scoreboard empty"}, 32'h1, 32'h0);
        exp_fn = 1'b1;
      end else begin
        exp_fn = exp_q.pop_front();
      end
      chk($sformatf("%s foundN s%0d", tag, k), 32'(found_N), 32'(exp_fn));
      if (end_frame) begin
        chk($sformatf("%s done s%0d", tag, k), 32'(done),  32'h1);
        chk({tag, " done grant"},              32'(grant), 32'h0);
        chk({tag, " done busy"},               32'(busy),  32'h0);
        break;
      end
      chk($sformatf("%s run done s%0d", tag, k), 32'(done), 32'h0);
      chk($sformatf("%s run grant s%0d", tag, k), 32'(grant), 32'(4'b0001 << id));
    end
    step();
    chk_idle({tag, " gap"});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    req     = '0;
    bit_in  = '0;
    do_reset();

    // Single stream, run of three zeros mid-frame.
    do_frame("t1", 4'b0001, 8'b1111_0001, 0);

    // All requesting: rotation 0,1,2,3 with overlap / broken run / tail run.
    do_reset();
    do_frame("t2a", 4'b1111, 8'b1110_0000, 0);
    do_frame("t2b", 4'b1111, 8'b1110_0100, 1);
    do_frame("t2c", 4'b1111, 8'b0001_1111, 2);
    do_frame("t2d", 4'b1111, 8'b1111_0001, 3);

    // Zeros straddling two frames of the same stream.
    do_frame("t5a", 4'b0010, 8'b0011_1111, 1);
    do_frame("t5b", 4'b0010, 8'b1111_1110, 1);

    // Reset during the 4th RUN cycle of a frame on stream 1.
    req = 4'b0010;
    step();
    chk("t4 grant", 32'(grant), 32'h2);
    bit_in = 4'b0000;
    step();
    step();
    step();
    chk("t4 busy before reset", 32'(busy), 32'h1);
    reset = 1'b1;
    step();
    chk_idle("t4 abort");
    chk("t4 abort found_id", 32'(found_id), 32'h0);
    reset = 1'b0;
    req   = 4'b0000;
    step();
    chk_idle("t4 after");
    do_frame("t4b", 4'b0101, 8'b1111_0001, 0);
    do_frame("t4c", 4'b0100, 8'b1110_0000, 2);

    // No requests: outputs idle, found_id holds.
    req = 4'b0000;
    step();
    step();
    chk_idle("idle");
    chk("idle found_id hold", 32'(found_id), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
